// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: operand/dest fields in, forward selects and
// pipeline enables out. master = datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        mem_busy;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_flush;
  logic        pipe_hold;
  logic        mem_timeout;
  logic [31:0] stall_count;

  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_rd, ex_mem_read,
    output mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_busy,
    input  forward_a, forward_b, pc_write, ifid_write,
    input  idex_flush, pipe_hold, mem_timeout, stall_count
  );

  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, ex_mem_read,
    input  mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_busy,
    output forward_a, forward_b, pc_write, ifid_write,
    output idex_flush, pipe_hold, mem_timeout, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Forwarding selects, load-use stall and mem-wait hold sequencing.
// Optional load-use stall counter: HAZARD_STALL_COUNT_EN.
module hazard_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_ctrl_if.slave   hz_if
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [15:0] LIMIT = 16'(WAIT_LIMIT);

  state_t      state;
  state_t      state_nxt;
  logic        hz;
  logic        busy;
  logic        pc_w;
  logic        ifid_w;
  logic        flush;
  logic        hold;
  logic [1:0]  fa;
  logic [1:0]  fb;
  logic [15:0] wait_cnt;
  logic        timeout;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] m_rd,
    input logic       m_we,
    input logic [4:0] w_rd,
    input logic       w_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && m_rd != 5'd0 && m_rd == src)
      sel = 2'b10;
    else if (w_we && w_rd != 5'd0 && w_rd == src)
      sel = 2'b01;
    return sel;
  endfunction

  assign busy = hz_if.mem_busy;

  assign fa = fwd_sel(hz_if.ex_rs,
                      hz_if.mem_rd, hz_if.mem_reg_write,
                      hz_if.wb_rd, hz_if.wb_reg_write);
  assign fb = fwd_sel(hz_if.ex_rt,
                      hz_if.mem_rd, hz_if.mem_reg_write,
                      hz_if.wb_rd, hz_if.wb_reg_write);

  assign hz = hz_if.ex_mem_read
           && hz_if.ex_rd != 5'd0
           && (hz_if.ex_rd == hz_if.id_rs
            || hz_if.ex_rd == hz_if.id_rt);

  // The cycle after a bubble masks hz so each hazard costs one stall.
  always_comb begin
    state_nxt = RUN;
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    flush     = 1'b0;
    hold      = 1'b0;
    unique case (1'b1)
      busy: begin
        state_nxt = MEM_WAIT;
        pc_w      = 1'b0;
        ifid_w    = 1'b0;
        hold      = 1'b1;
      end
      (!busy && hz && state != LOAD_STALL): begin
        state_nxt = LOAD_STALL;
        pc_w      = 1'b0;
        ifid_w    = 1'b0;
        flush     = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 16'd0;
      timeout  <= 1'b0;
    end else if (busy) begin
      if (wait_cnt != LIMIT)
        wait_cnt <= wait_cnt + 16'd1;
      if (wait_cnt == LIMIT - 16'd1)
        timeout <= 1'b1;
    end else begin
      wait_cnt <= 16'd0;
    end
  end

  // Reset forces the idle outputs regardless of the inputs.
  assign hz_if.forward_a   = rst_n ? fa : 2'b00;
  assign hz_if.forward_b   = rst_n ? fb : 2'b00;
  assign hz_if.pc_write    = !rst_n || pc_w;
  assign hz_if.ifid_write  = !rst_n || ifid_w;
  assign hz_if.idex_flush  = rst_n && flush;
  assign hz_if.pipe_hold   = rst_n && hold;
  assign hz_if.mem_timeout = timeout;

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] scnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt <= 32'd0;
    end else if (flush && scnt != 32'hFFFF_FFFF) begin
      scnt <= scnt + 32'd1;
    end
  end

  assign hz_if.stall_count = scnt;
`else
  assign hz_if.stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and random checks of hazard_ctrl against a cycle-level
// behavioural model (WAIT_LIMIT = 4).
module tb_hazard_ctrl;

  localparam int WL = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.WAIT_LIMIT(WL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  bit      m_prev_bubble;
  int      m_busy_run;
  bit      m_to;
  longint  m_stalls;
  logic [1:0] e_fa, e_fb;
  logic e_pcw, e_ifw, e_fl, e_hold;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (bus.mem_reg_write && bus.mem_rd != 0 && bus.mem_rd == src)
      return 2'b10;
    if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == src)
      return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_sc();
`ifdef HAZARD_STALL_COUNT_EN
    return (m_stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_stalls);
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_prev_bubble = 0;
    m_busy_run    = 0;
    m_to          = 0;
    m_stalls      = 0;
  endtask

  task automatic predict();
    bit h;
    h = bus.ex_mem_read && bus.ex_rd != 0
        && (bus.ex_rd == bus.id_rs || bus.ex_rd == bus.id_rt);
    e_fa   = m_fwd(bus.ex_rs);
    e_fb   = m_fwd(bus.ex_rt);
    e_hold = bus.mem_busy;
    e_fl   = !bus.mem_busy && h && !m_prev_bubble;
    e_pcw  = !bus.mem_busy && !e_fl;
    e_ifw  = e_pcw;
  endtask

  task automatic chk_all(input string tag);
    predict();
    chk({tag, ".fa"}, 32'(bus.forward_a), 32'(e_fa));
    chk({tag, ".fb"}, 32'(bus.forward_b), 32'(e_fb));
    chk({tag, ".pcw"}, 32'(bus.pc_write), 32'(e_pcw));
    chk({tag, ".ifw"}, 32'(bus.ifid_write), 32'(e_ifw));
    chk({tag, ".flush"}, 32'(bus.idex_flush), 32'(e_fl));
    chk({tag, ".hold"}, 32'(bus.pipe_hold), 32'(e_hold));
  endtask

  // inputs already driven after a negedge: check, clock, check regs
  task automatic cyc(input string tag);
    #2;
    chk_all(tag);
    m_prev_bubble = e_fl;
    if (bus.mem_busy) begin
      m_busy_run++;
      if (m_busy_run >= WL) m_to = 1;
    end else begin
      m_busy_run = 0;
    end
    if (e_fl) m_stalls++;
    @(posedge clk);
    #1;
    chk({tag, ".to"}, 32'(bus.mem_timeout), 32'(m_to));
    chk({tag, ".sc"}, bus.stall_count, m_sc());
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.id_rs = 0; bus.id_rt = 0;
    bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_rd = 0;
    bus.ex_mem_read = 0;
    bus.mem_rd = 0; bus.mem_reg_write = 0;
    bus.wb_rd = 0; bus.wb_reg_write = 0;
    bus.mem_busy = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".fa"}, 32'(bus.forward_a), 0);
    chk({tag, ".fb"}, 32'(bus.forward_b), 0);
    chk({tag, ".pcw"}, 32'(bus.pc_write), 1);
    chk({tag, ".ifw"}, 32'(bus.ifid_write), 1);
    chk({tag, ".flush"}, 32'(bus.idex_flush), 0);
    chk({tag, ".hold"}, 32'(bus.pipe_hold), 0);
    chk({tag, ".to"}, 32'(bus.mem_timeout), 0);
    chk({tag, ".sc"}, bus.stall_count, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    idle_inputs();
    rst_n = 1'b0;
    // hostile inputs during reset
    bus.ex_rs = 5; bus.mem_rd = 5; bus.mem_reg_write = 1;
    bus.ex_mem_read = 1; bus.ex_rd = 3; bus.id_rs = 3;
    bus.mem_busy = 1;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("rst0");
    idle_inputs();
    rst_n = 1'b1;

    // forwarding priority and register 0
    bus.ex_rs = 5; bus.mem_rd = 5; bus.mem_reg_write = 1;
    bus.wb_rd = 5; bus.wb_reg_write = 1;
    #1 chk("fwd.exmem", 32'(bus.forward_a), 32'b10);
    cyc("fwd1");
    bus.mem_reg_write = 0;
    #1 chk("fwd.memwb", 32'(bus.forward_a), 32'b01);
    cyc("fwd2");
    bus.mem_rd = 0; bus.mem_reg_write = 1;
    #1 chk("fwd.r0", 32'(bus.forward_a), 32'b01);
    bus.ex_rt = 5;
    #1 chk("fwd.b", 32'(bus.forward_b), 32'b01);
    cyc("fwd3");
    idle_inputs();

    // single load-use stall
    bus.ex_mem_read = 1; bus.ex_rd = 8; bus.id_rt = 8;
    #1 chk("lu.flush", 32'(bus.idex_flush), 1);
    chk("lu.pcw", 32'(bus.pc_write), 0);
    cyc("lu1");
    bus.ex_mem_read = 0;
    #1 chk("lu.after", 32'(bus.pc_write), 1);
    cyc("lu2");
`ifdef HAZARD_STALL_COUNT_EN
    chk("lu.sc", bus.stall_count, 1);
`else
    chk("lu.sc", bus.stall_count, 0);
`endif

    // mem_busy outranks a pending hazard, bubble on release
    bus.ex_mem_read = 1; bus.ex_rd = 9; bus.id_rs = 9;
    bus.mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw.hold", 32'(bus.pipe_hold), 1);
      chk("mw.noflush", 32'(bus.idex_flush), 0);
      cyc("mw");
    end
    chk("mw.to3", 32'(bus.mem_timeout), 0);
    bus.mem_busy = 0;
    #1 chk("mw.bubble", 32'(bus.idex_flush), 1);
    cyc("mw.rel");
    idle_inputs();
    cyc("mw.idle");

    // watchdog: 4 busy edges set sticky timeout
    bus.mem_busy = 1;
    repeat (4) cyc("wd");
    chk("wd.set", 32'(bus.mem_timeout), 1);
    bus.mem_busy = 0;
    cyc("wd.sticky");
    chk("wd.hold1", 32'(bus.mem_timeout), 1);

    // random traffic over small register numbers
    for (int n = 0; n < 400; n++) begin
      bus.id_rs = 5'($urandom_range(0, 3));
      bus.id_rt = 5'($urandom_range(0, 3));
      bus.ex_rs = 5'($urandom_range(0, 3));
      bus.ex_rt = 5'($urandom_range(0, 3));
      bus.ex_rd = 5'($urandom_range(0, 3));
      bus.ex_mem_read = ($urandom_range(0, 2) != 0);
      bus.mem_rd = 5'($urandom_range(0, 3));
      bus.mem_reg_write = $urandom_range(0, 1);
      bus.wb_rd = 5'($urandom_range(0, 3));
      bus.wb_reg_write = $urandom_range(0, 1);
      bus.mem_busy = ($urandom_range(0, 5) == 0);
      cyc("rnd");
    end

    // reset mid LOAD_STALL with timeout set
    idle_inputs();
    bus.mem_busy = 1;
    repeat (4) cyc("pre");
    bus.mem_busy = 0;
    bus.ex_mem_read = 1; bus.ex_rd = 4; bus.id_rs = 4;
    cyc("pre.lu");
    chk("pre.to", 32'(bus.mem_timeout), 1);
    bus.ex_rs = 6; bus.mem_rd = 6; bus.mem_reg_write = 1;
    bus.mem_busy = 1;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst1");
    model_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    #1 chk("rel.pcw", 32'(bus.pc_write), 1);
    cyc("rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the MIPS datapath. It drives the 2-bit select inputs of the two 3-input ALU-operand multiplexers, choosing among register file, MEM/WB result and EX/MEM result. It also sequences pipeline freezes for load-use hazards and for data-memory wait states. It sits beside the ID/EX stage and feeds the PC, the IF/ID register, the ID/EX register and the global pipeline hold.

## Interface
Parameters:
- WAIT_LIMIT, 255: consecutive mem_busy cycles before mem_timeout sets; legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- ex_rs, ex_rt  in  5 each  source registers of the instruction in EX.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- mem_rd, mem_reg_write  in  5, 1  EX/MEM destination and write-enable.
- wb_rd, wb_reg_write  in  5, 1  MEM/WB destination and write-enable.
- mem_busy  in  1  data memory not ready this cycle.
- forward_a, forward_b  out  2 each  ALU operand mux selects: 00 = register file, 01 = MEM/WB, 10 = EX/MEM. 11 is never driven.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- idex_flush  out  1  load a bubble into ID/EX.
- pipe_hold  out  1  freeze every pipeline register.
- mem_timeout  out  1  sticky watchdog flag.
- stall_count  out  32  load-use stall count; see Configuration.

## Operation
- Forwarding (combinational, from the current inputs):
  - forward_a = 10 if mem_reg_write && mem_rd != 0 && mem_rd == ex_rs.
  - Otherwise forward_a = 01 if wb_reg_write && wb_rd != 0 && wb_rd == ex_rs.
  - Otherwise forward_a = 00.
  - forward_b uses the same rules with ex_rt.
  - EX/MEM takes priority over MEM/WB. Register 0 is never forwarded.
- Load-use hazard: hz = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt).
- FSM states: RUN, LOAD_STALL, MEM_WAIT.
  - Any state with mem_busy = 1: next state is MEM_WAIT. Outputs pipe_hold = 1, pc_write = 0, ifid_write = 0, idex_flush = 0. mem_busy outranks hz.
  - RUN with mem_busy = 0 and hz = 1: next state is LOAD_STALL. Outputs pc_write = 0, ifid_write = 0, idex_flush = 1, pipe_hold = 0.
  - RUN with mem_busy = 0 and hz = 0: stay in RUN. Outputs pc_write = 1, ifid_write = 1, idex_flush = 0, pipe_hold = 0.
  - LOAD_STALL with mem_busy = 0: hz is masked, outputs are the RUN defaults, next state is RUN.
  - MEM_WAIT with mem_busy = 0: hz is evaluated exactly as in RUN (a stall may be issued this cycle), and the next state follows the RUN rules.
- Watchdog:
  - wait_cnt (16 bit) increments on each edge where mem_busy = 1, saturating at WAIT_LIMIT. It clears on any edge where mem_busy = 0.
  - mem_timeout sets on the edge where mem_busy = 1 and wait_cnt == WAIT_LIMIT-1.
  - mem_timeout stays set until reset.

## Timing
- Forward selects and stall/hold outputs are Mealy: valid in the same cycle as their inputs, with zero latency.
- Registered state: FSM state, wait_cnt, mem_timeout, stall_count. All update on the rising clk edge.
- While rst_n = 0, asynchronously and regardless of other inputs:
  - state = RUN, wait_cnt = 0.
  - forward_a = forward_b = 00.
  - pc_write = 1, ifid_write = 1, idex_flush = 0, pipe_hold = 0.
  - mem_timeout = 0, stall_count = 0.
- Reset asserted mid-stall or mid-wait aborts immediately. The first cycle after release behaves as RUN.
- A load-use stall lasts exactly one cycle per hazard. Back-to-back dependent loads produce one stall each, separated by at least one RUN cycle.
- When mem_busy drops with hz pending, the bubble is inserted in that same cycle.

## Configuration
- Macro HAZARD_STALL_COUNT_EN.
- Defined: stall_count increments on every edge where idex_flush = 1, saturating at 32'hFFFF_FFFF.
- Undefined: no counter register is built and stall_count is driven constant 0.

## Test plan
- ex_rs = 5, mem_rd = 5, mem_reg_write = 1, wb_rd = 5, wb_reg_write = 1 -> forward_a = 10. Then clear mem_reg_write -> forward_a = 01. Then set mem_rd = 0 with mem_reg_write = 1 -> forward_a = 01 (register 0 not forwarded, MEM/WB still matches).
- ex_mem_read = 1, ex_rd = 8, id_rt = 8 -> one cycle of pc_write = 0, ifid_write = 0, idex_flush = 1. Next cycle (bubble, ex_mem_read = 0) -> all defaults. stall_count = 1 with the macro, 0 without.
- mem_busy = 1 for 3 cycles while hz = 1 -> pipe_hold = 1 and idex_flush = 0 for 3 cycles. On the cycle mem_busy falls -> idex_flush = 1 for one cycle.
- WAIT_LIMIT = 4, mem_busy held 3 cycles -> mem_timeout stays 0. Held 4 cycles -> mem_timeout = 1 after the 4th edge and stays 1 after mem_busy falls.
- Drop rst_n during LOAD_STALL with mem_timeout = 1 -> all outputs return to reset values immediately. After release, hz = 0 gives pc_write = 1.
- HAZARD_STALL_COUNT_EN defined, stall_count forced near saturation via 2^32 stalls or a backdoor -> holds at 32'hFFFF_FFFF without wrapping.
